demux_rr_sched: RTL

- Round-robin distributor wrapped around the 1-to-8 demux path.
- Accepts one data word on a valid/ready input, then steers it to one of 8 output channels.
- Drives the channel select and a one-hot per-channel valid, skipping masked channels.
- Reroutes a word to the next enabled channel when its channel stalls past a timeout.

---
 rtl/demux_sched_pkg.sv | 9 +
 rtl/demux_rr_sched_rr_pick8.sv | 15 +
 rtl/demux_rr_sched.sv | 75 +++++++
 3 files changed

// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared constants, FSM state type and select decode for the round-robin demux.
package demux_sched_pkg;
    localparam int NCH = 8;
    localparam int SEL_W = 3;
    typedef enum logic {IDLE, HOLD} state_t;
    function automatic logic [NCH-1:0] onehot8(input logic [SEL_W-1:0] s);
        return NCH'(1) << s;
    endfunction
endpackage

// File: rtl/demux_rr_sched_rr_pick8.sv
// rr_pick8: first set mask bit strictly after ptr, wrapping; returns ptr when it is the only set bit.
module rr_pick8 (
    input  logic [7:0] mask,
    input  logic [2:0] ptr,
    output logic [2:0] pick,
    output logic       any
);
    // Scan farthest-first so the nearest eligible channel wins; offset 8 wraps back to ptr.
    always_comb begin
        pick = ptr;
        for (int i = 8; i >= 1; i--)
            if (mask[ptr + 3'(i)]) pick = ptr + 3'(i);
    end
    assign any = |mask;
endmodule

// File: rtl/demux_rr_sched.sv
// demux_rr_sched: accepts one word, offers it round-robin to an enabled channel,
// and reroutes it when the channel is masked off or stalls for TIMEOUT cycles.
module demux_rr_sched
    import demux_sched_pkg::*;
#(
    parameter int DW = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NCH-1:0]   ch_mask,
    output logic [SEL_W-1:0] sel,
    output logic [DW-1:0]    out_data,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic             skip,
    output logic             busy
);
    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [7:0]       tcnt;
    logic [SEL_W-1:0] pick;
    logic             any;
    logic             done;
    logic             reroute;

    // One picker serves both the initial grant (from ptr) and reroutes (from sel).
    rr_pick8 u_pick (
        .mask(ch_mask),
        .ptr (state == IDLE ? ptr : sel),
        .pick(pick),
        .any (any)
    );

    assign busy      = state == HOLD;
    assign in_ready  = en & any & (state == IDLE);
    assign out_valid = (busy & en & any) ? onehot8(sel) : '0;
    assign done      = out_ready[sel] & out_valid[sel];
    assign reroute   = busy & en & ~done & any & (~ch_mask[sel] | (tcnt == 8'(TIMEOUT - 1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '1;
            sel      <= '0;
            out_data <= '0;
            skip     <= 1'b0;
            tcnt     <= '0;
        end else begin
            skip <= reroute;
            if (state == IDLE) begin
                if (in_valid & in_ready) begin
                    out_data <= in_data;
                    sel      <= pick;
                    tcnt     <= '0;
                    state    <= HOLD;
                end
            end else if (en) begin
                if (done) begin
                    ptr   <= sel;
                    state <= IDLE;
                end else if (reroute) begin
                    sel  <= pick;
                    tcnt <= '0;
                end else if (any) begin
                    tcnt <= tcnt + 8'd1;
                end
            end
        end
    end
endmodule
